// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative, write-back / write-allocate cache controller.
// Blocking single-request engine: IDLE -> LOOKUP -> (WB) -> (FILL) -> RESP.
// Replacement is true LRU: per-set age ranks, rank WAYS-1 is the victim.
module set_assoc_cache_ctrl #(
    parameter int TAG_W  = 3,
    parameter int SET_W  = 3,
    parameter int OFF_W  = 1,
    parameter int DATA_W = 8,
    parameter int WAYS   = 2,
    parameter int CNT_W  = 16,
    parameter int BLK_W  = DATA_W << OFF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [SET_W-1:0]  req_set,
    input  logic [OFF_W-1:0]  req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [TAG_W-1:0]  mem_req_tag,
    output logic [SET_W-1:0]  mem_req_set,
    output logic [BLK_W-1:0]  mem_req_wblock,
    input  logic              mem_resp_valid,
    input  logic [BLK_W-1:0]  mem_resp_block,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int SETS  = 1 << SET_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_WB     = 3'd2;
    localparam logic [2:0] ST_FILL   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    // Storage: status bits are reset, tags and data are not.
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_arr_q  [SETS][WAYS];
    logic [BLK_W-1:0]  data_arr_q [SETS][WAYS];

    logic [2:0]        state_q, state_d;
    logic              rq_write_q;
    logic [TAG_W-1:0]  rq_tag_q;
    logic [SET_W-1:0]  rq_set_q;
    logic [OFF_W-1:0]  rq_off_q;
    logic [DATA_W-1:0] rq_wdata_q;
    logic [WAY_W-1:0]  way_q;
    logic              fill_acc_q;
    logic              resp_valid_q, resp_hit_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              mem_valid_q, mem_write_q;
    logic [TAG_W-1:0]  mem_tag_q;
    logic [SET_W-1:0]  mem_set_q;
    logic [BLK_W-1:0]  mem_wblock_q;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

    logic              hit_s, inv_found_s, vict_dirty_s, install_s, acc_s;
    logic [WAY_W-1:0]  hit_way_s, lru_way_s, vict_way_s, acc_way_s;
    logic [BLK_W-1:0]  hit_blk_s, wr_blk_s, fill_blk_s;
    logic [DATA_W-1:0] hit_entry_s, fill_entry_s;

    assign req_ready      = (state_q == ST_IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_hit       = resp_hit_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_req_valid  = mem_valid_q;
    assign mem_req_write  = mem_write_q;
    assign mem_req_tag    = mem_tag_q;
    assign mem_req_set    = mem_set_q;
    assign mem_req_wblock = mem_wblock_q;
    assign hit_cnt        = hit_cnt_q;
    assign miss_cnt       = miss_cnt_q;

    // Tag compare, victim choice and block merge for the latched request.
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = '0;
        lru_way_s   = '0;
        inv_found_s = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[rq_set_q][w] && (tag_arr_q[rq_set_q][w] == rq_tag_q)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_s     = hit_s;
            end
            if (age_q[rq_set_q][w] == WAY_W'(WAYS - 1)) begin
                lru_way_s = WAY_W'(w);
            end else begin
                lru_way_s = lru_way_s;
            end
        end
        vict_way_s = lru_way_s;
        // Scan downwards so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[rq_set_q][w]) begin
                vict_way_s  = WAY_W'(w);
                inv_found_s = 1'b1;
            end else begin
                inv_found_s = inv_found_s;
            end
        end
        vict_dirty_s = !inv_found_s && dirty_q[rq_set_q][vict_way_s];
        hit_blk_s    = data_arr_q[rq_set_q][hit_way_s];
        hit_entry_s  = hit_blk_s[rq_off_q*DATA_W +: DATA_W];
        wr_blk_s     = hit_blk_s;
        wr_blk_s[rq_off_q*DATA_W +: DATA_W] = rq_wdata_q;
        fill_entry_s = mem_resp_block[rq_off_q*DATA_W +: DATA_W];
        fill_blk_s   = mem_resp_block;
        if (rq_write_q) begin
            fill_blk_s[rq_off_q*DATA_W +: DATA_W] = rq_wdata_q;
        end else begin
            fill_blk_s = mem_resp_block;
        end
        install_s = (state_q == ST_FILL) && fill_acc_q && mem_resp_valid;
        acc_s     = ((state_q == ST_LOOKUP) && hit_s) || install_s;
        acc_way_s = (state_q == ST_LOOKUP) ? hit_way_s : way_q;
    end

    // Next-state decode of the request FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = req_valid ? ST_LOOKUP : ST_IDLE;
            ST_LOOKUP: state_d = hit_s ? ST_RESP : (vict_dirty_s ? ST_WB : ST_FILL);
            ST_WB:     state_d = mem_req_ready ? ST_FILL : ST_WB;
            ST_FILL:   state_d = install_s ? ST_RESP : ST_FILL;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM state, request latch, memory request, response and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rq_write_q   <= 1'b0;
            rq_tag_q     <= '0;
            rq_set_q     <= '0;
            rq_off_q     <= '0;
            rq_wdata_q   <= '0;
            way_q        <= '0;
            fill_acc_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_valid_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_tag_q    <= '0;
            mem_set_q    <= '0;
            mem_wblock_q <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        rq_write_q <= req_write;
                        rq_tag_q   <= req_tag;
                        rq_set_q   <= req_set;
                        rq_off_q   <= req_offset;
                        rq_wdata_q <= req_wdata;
                    end else begin
                        rq_write_q <= rq_write_q;
                    end
                end
                ST_LOOKUP: begin
                    way_q <= hit_s ? hit_way_s : vict_way_s;
                    if (hit_s) begin
                        if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                        else hit_cnt_q <= hit_cnt_q;
                        if (rq_write_q) dirty_q[rq_set_q][hit_way_s] <= 1'b1;
                        else dirty_q[rq_set_q][hit_way_s] <= dirty_q[rq_set_q][hit_way_s];
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        resp_rdata_q <= rq_write_q ? rq_wdata_q : hit_entry_s;
                    end else begin
                        if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                        else miss_cnt_q <= miss_cnt_q;
                        mem_valid_q <= 1'b1;
                        if (vict_dirty_s) begin
                            mem_write_q  <= 1'b1;
                            mem_tag_q    <= tag_arr_q[rq_set_q][vict_way_s];
                            mem_set_q    <= rq_set_q;
                            mem_wblock_q <= data_arr_q[rq_set_q][vict_way_s];
                        end else begin
                            mem_write_q  <= 1'b0;
                            mem_tag_q    <= rq_tag_q;
                            mem_set_q    <= rq_set_q;
                            mem_wblock_q <= '0;
                        end
                    end
                end
                ST_WB: begin
                    if (mem_req_ready) begin
                        mem_write_q  <= 1'b0;
                        mem_tag_q    <= rq_tag_q;
                        mem_set_q    <= rq_set_q;
                        mem_wblock_q <= '0;
                    end else begin
                        mem_write_q  <= mem_write_q;
                    end
                end
                ST_FILL: begin
                    if (!fill_acc_q) begin
                        if (mem_req_ready) begin
                            mem_valid_q <= 1'b0;
                            fill_acc_q  <= 1'b1;
                        end else begin
                            fill_acc_q  <= 1'b0;
                        end
                    end else if (mem_resp_valid) begin
                        fill_acc_q                <= 1'b0;
                        valid_q[rq_set_q][way_q]  <= 1'b1;
                        dirty_q[rq_set_q][way_q]  <= rq_write_q;
                        resp_valid_q              <= 1'b1;
                        resp_hit_q                <= 1'b0;
                        resp_rdata_q              <= rq_write_q ? rq_wdata_q : fill_entry_s;
                    end else begin
                        fill_acc_q <= fill_acc_q;
                    end
                end
                ST_RESP: resp_hit_q <= 1'b0;
                default: resp_hit_q <= 1'b0;
            endcase
        end
    end

    // LRU ranks: the accessed way becomes 0, younger ways age by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else if (acc_s) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[rq_set_q][w] < age_q[rq_set_q][acc_way_s]) begin
                    age_q[rq_set_q][w] <= age_q[rq_set_q][w] + WAY_W'(1);
                end else begin
                    age_q[rq_set_q][w] <= age_q[rq_set_q][w];
                end
            end
            age_q[rq_set_q][acc_way_s] <= '0;
        end else begin
            age_q[rq_set_q][0] <= age_q[rq_set_q][0];
        end
    end

    // Tag and data arrays: write hits merge in place, fills install a block.
    always_ff @(posedge clk) begin
        if ((state_q == ST_LOOKUP) && hit_s && rq_write_q) begin
            data_arr_q[rq_set_q][hit_way_s] <= wr_blk_s;
        end else if (install_s) begin
            data_arr_q[rq_set_q][way_q] <= fill_blk_s;
            tag_arr_q[rq_set_q][way_q]  <= rq_tag_q;
        end else begin
            data_arr_q[rq_set_q][way_q] <= data_arr_q[rq_set_q][way_q];
        end
    end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl (default parameters, 2 ways).
module tb_set_assoc_cache_ctrl;
    localparam int TAG_W = 3, SET_W = 3, OFF_W = 1, DATA_W = 8, CNT_W = 16;
    localparam int BLK_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [SET_W-1:0] req_set = '0;
    logic [OFF_W-1:0] req_offset = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic resp_valid, resp_hit;
    logic [DATA_W-1:0] resp_rdata;
    logic mem_req_valid, mem_req_ready = 1'b0, mem_req_write;
    logic [TAG_W-1:0] mem_req_tag;
    logic [SET_W-1:0] mem_req_set;
    logic [BLK_W-1:0] mem_req_wblock;
    logic mem_resp_valid = 1'b0;
    logic [BLK_W-1:0] mem_resp_block = '0;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations recorded by the request driver.
    logic got_hit;
    logic [DATA_W-1:0] got_rdata;
    int lat, n_wb, n_fill, unstable_n, busy_rdy_n, stalled_n, timeouts;
    logic [TAG_W-1:0] wb_tag, fill_tag;
    logic [SET_W-1:0] wb_set, fill_set;
    logic [BLK_W-1:0] wb_block;

    set_assoc_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_tag(req_tag), .req_set(req_set), .req_offset(req_offset), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
        .mem_req_tag(mem_req_tag), .mem_req_set(mem_req_set), .mem_req_wblock(mem_req_wblock),
        .mem_resp_valid(mem_resp_valid), .mem_resp_block(mem_resp_block),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Issue one request and act as memory; each memory request is stalled 'stall' cycles.
    task automatic issue(input logic w, input logic [TAG_W-1:0] tg, input logic [SET_W-1:0] st,
                         input logic [OFF_W-1:0] off, input logic [DATA_W-1:0] wd,
                         input logic [BLK_W-1:0] fb, input int stall);
        int c, left;
        logic done, newreq, pend;
        logic snap_w;
        logic [TAG_W-1:0] snap_t;
        logic [SET_W-1:0] snap_s;
        logic [BLK_W-1:0] snap_b;
        got_hit = 1'bx; got_rdata = 'x; lat = -1;
        n_wb = 0; n_fill = 0; unstable_n = 0; busy_rdy_n = 0; stalled_n = 0;
        wb_tag = 'x; wb_set = 'x; wb_block = 'x; fill_tag = 'x; fill_set = 'x;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_tag = tg; req_set = st; req_offset = off; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        done = 1'b0; newreq = 1'b1; pend = 1'b0; left = 0; c = 0;
        snap_w = 1'b0; snap_t = '0; snap_s = '0; snap_b = '0;
        while (!done && c < 100) begin
            @(negedge clk);
            c++;
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b0;
            if (req_ready) busy_rdy_n++;
            if (resp_valid) begin
                got_hit = resp_hit; got_rdata = resp_rdata; lat = c + 1; done = 1'b1;
            end else begin
                if (pend) begin
                    mem_resp_valid = 1'b1; mem_resp_block = fb; pend = 1'b0;
                end
                if (mem_req_valid) begin
                    if (newreq) begin
                        snap_w = mem_req_write; snap_t = mem_req_tag; snap_s = mem_req_set; snap_b = mem_req_wblock;
                        newreq = 1'b0; left = stall;
                    end else if ({mem_req_write, mem_req_tag, mem_req_set, mem_req_wblock} !== {snap_w, snap_t, snap_s, snap_b}) begin
                        unstable_n++;
                    end
                    if (left > 0) begin
                        left--; stalled_n++;
                    end else begin
                        mem_req_ready = 1'b1; newreq = 1'b1;
                        if (mem_req_write) begin
                            n_wb++; wb_tag = mem_req_tag; wb_set = mem_req_set; wb_block = mem_req_wblock;
                        end else begin
                            n_fill++; fill_tag = mem_req_tag; fill_set = mem_req_set; pend = 1'b1;
                        end
                    end
                end
            end
        end
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        if (!done) timeouts++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        n_tests++; if (resp_hit !== 1'b0) begin n_fail++; $display("FAIL rst_resp_hit got=%b exp=0", resp_hit); end
        n_tests++; if (resp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got=%h exp=00", resp_rdata); end
        n_tests++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid got=%b exp=0", mem_req_valid); end
        n_tests++; if ({mem_req_write, mem_req_tag, mem_req_set, mem_req_wblock} !== 23'd0) begin n_fail++; $display("FAIL rst_mem_fields got=%h exp=0", {mem_req_write, mem_req_tag, mem_req_set, mem_req_wblock}); end
        n_tests++; if ({hit_cnt, miss_cnt} !== 32'd0) begin n_fail++; $display("FAIL rst_counters got=%h exp=0", {hit_cnt, miss_cnt}); end
    endtask

    task automatic test_cold_miss();
        issue(1'b0, 3'd2, 3'd1, 1'b0, 8'h00, 16'hBEEF, 0);
        n_tests++; if (got_hit !== 1'b0) begin n_fail++; $display("FAIL cold_hit got=%b exp=0", got_hit); end
        n_tests++; if (got_rdata !== 8'hEF) begin n_fail++; $display("FAIL cold_rdata got=%h exp=ef", got_rdata); end
        n_tests++; if ({fill_tag, fill_set} !== {3'd2, 3'd1}) begin n_fail++; $display("FAIL cold_fill_addr got=%0d/%0d exp=2/1", fill_tag, fill_set); end
        n_tests++; if (n_wb !== 0) begin n_fail++; $display("FAIL cold_no_wb got=%0d exp=0", n_wb); end
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL cold_latency got=%0d exp=4", lat); end
        issue(1'b0, 3'd2, 3'd1, 1'b0, 8'h00, 16'h0000, 0);
        n_tests++; if (got_hit !== 1'b1) begin n_fail++; $display("FAIL reread_hit got=%b exp=1", got_hit); end
        n_tests++; if (got_rdata !== 8'hEF) begin n_fail++; $display("FAIL reread_rdata got=%h exp=ef", got_rdata); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL hit_latency got=%0d exp=2", lat); end
        n_tests++; if (n_fill !== 0) begin n_fail++; $display("FAIL reread_no_fill got=%0d exp=0", n_fill); end
    endtask

    task automatic test_write_hit();
        issue(1'b1, 3'd2, 3'd1, 1'b1, 8'h5A, 16'h0000, 0);
        n_tests++; if (got_hit !== 1'b1) begin n_fail++; $display("FAIL wr_hit got=%b exp=1", got_hit); end
        n_tests++; if (got_rdata !== 8'h5A) begin n_fail++; $display("FAIL wr_rdata got=%h exp=5a", got_rdata); end
        n_tests++; if (hit_cnt !== 16'd2) begin n_fail++; $display("FAIL wr_hit_cnt got=%0d exp=2", hit_cnt); end
        n_tests++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL wr_miss_cnt got=%0d exp=1", miss_cnt); end
        issue(1'b0, 3'd2, 3'd1, 1'b1, 8'h00, 16'h0000, 0);
        n_tests++; if ({got_hit, got_rdata} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL rdback got=%b/%h exp=1/5a", got_hit, got_rdata); end
        n_tests++; if (hit_cnt !== 16'd3) begin n_fail++; $display("FAIL rdback_hit_cnt got=%0d exp=3", hit_cnt); end
    endtask

    task automatic test_dirty_evict();
        issue(1'b0, 3'd3, 3'd1, 1'b0, 8'h00, 16'h1234, 0);
        n_tests++; if ({got_hit, got_rdata, n_wb} !== {1'b0, 8'h34, 32'd0}) begin n_fail++; $display("FAIL fill3 got=%b/%h/%0d exp=0/34/0", got_hit, got_rdata, n_wb); end
        issue(1'b0, 3'd3, 3'd1, 1'b1, 8'h00, 16'h0000, 0);
        n_tests++; if ({got_hit, got_rdata} !== {1'b1, 8'h12}) begin n_fail++; $display("FAIL touch3 got=%b/%h exp=1/12", got_hit, got_rdata); end
        issue(1'b0, 3'd4, 3'd1, 1'b0, 8'h00, 16'hC0DE, 0);
        n_tests++; if (n_wb !== 1) begin n_fail++; $display("FAIL evict_wb_count got=%0d exp=1", n_wb); end
        n_tests++; if ({wb_tag, wb_set} !== {3'd2, 3'd1}) begin n_fail++; $display("FAIL evict_wb_addr got=%0d/%0d exp=2/1", wb_tag, wb_set); end
        n_tests++; if (wb_block !== 16'h5AEF) begin n_fail++; $display("FAIL evict_wb_block got=%h exp=5aef", wb_block); end
        n_tests++; if ({fill_tag, fill_set} !== {3'd4, 3'd1}) begin n_fail++; $display("FAIL evict_fill_addr got=%0d/%0d exp=4/1", fill_tag, fill_set); end
        n_tests++; if ({got_hit, got_rdata} !== {1'b0, 8'hDE}) begin n_fail++; $display("FAIL evict_resp got=%b/%h exp=0/de", got_hit, got_rdata); end
        issue(1'b0, 3'd3, 3'd1, 1'b0, 8'h00, 16'h0000, 0);
        n_tests++; if ({got_hit, got_rdata} !== {1'b1, 8'h34}) begin n_fail++; $display("FAIL tag3_after got=%b/%h exp=1/34", got_hit, got_rdata); end
        n_tests++; if ({hit_cnt, miss_cnt} !== {16'd5, 16'd3}) begin n_fail++; $display("FAIL evict_cnts got=%0d/%0d exp=5/3", hit_cnt, miss_cnt); end
    endtask

    task automatic test_clean_evict();
        // Way 0 (tag 4, clean) is now LRU in set 1.
        issue(1'b0, 3'd5, 3'd1, 1'b1, 8'h00, 16'h7788, 0);
        n_tests++; if (n_wb !== 0) begin n_fail++; $display("FAIL clean_no_wb got=%0d exp=0", n_wb); end
        n_tests++; if ({n_fill, fill_tag, fill_set} !== {32'd1, 3'd5, 3'd1}) begin n_fail++; $display("FAIL clean_fill got=%0d %0d/%0d exp=1 5/1", n_fill, fill_tag, fill_set); end
        n_tests++; if ({got_hit, got_rdata} !== {1'b0, 8'h77}) begin n_fail++; $display("FAIL clean_resp got=%b/%h exp=0/77", got_hit, got_rdata); end
        issue(1'b0, 3'd3, 3'd1, 1'b0, 8'h00, 16'h0000, 0);
        n_tests++; if ({got_hit, got_rdata} !== {1'b1, 8'h34}) begin n_fail++; $display("FAIL clean_keep3 got=%b/%h exp=1/34", got_hit, got_rdata); end
    endtask

    task automatic test_backpressure();
        issue(1'b1, 3'd1, 3'd2, 1'b0, 8'h11, 16'hAAAA, 0);
        n_tests++; if ({got_hit, got_rdata} !== {1'b0, 8'h11}) begin n_fail++; $display("FAIL bp_wr1 got=%b/%h exp=0/11", got_hit, got_rdata); end
        issue(1'b1, 3'd2, 3'd2, 1'b1, 8'h22, 16'hBBBB, 0);
        n_tests++; if (n_wb !== 0) begin n_fail++; $display("FAIL bp_wr2_no_wb got=%0d exp=0", n_wb); end
        issue(1'b0, 3'd3, 3'd2, 1'b0, 8'h00, 16'hCCDD, 3);
        n_tests++; if ({wb_tag, wb_set, wb_block} !== {3'd1, 3'd2, 16'hAA11}) begin n_fail++; $display("FAIL bp_wb got=%0d/%0d/%h exp=1/2/aa11", wb_tag, wb_set, wb_block); end
        n_tests++; if ({fill_tag, fill_set} !== {3'd3, 3'd2}) begin n_fail++; $display("FAIL bp_fill got=%0d/%0d exp=3/2", fill_tag, fill_set); end
        n_tests++; if (stalled_n !== 6) begin n_fail++; $display("FAIL bp_stalls got=%0d exp=6", stalled_n); end
        n_tests++; if (unstable_n !== 0) begin n_fail++; $display("FAIL bp_stable got=%0d exp=0", unstable_n); end
        n_tests++; if (busy_rdy_n !== 0) begin n_fail++; $display("FAIL bp_req_ready got=%0d exp=0", busy_rdy_n); end
        n_tests++; if ({got_hit, got_rdata, lat} !== {1'b0, 8'hDD, 32'd11}) begin n_fail++; $display("FAIL bp_resp got=%b/%h/%0d exp=0/dd/11", got_hit, got_rdata, lat); end
    endtask

    task automatic test_reset_in_fill();
        int c;
        logic seen;
        logic stray;
        issue(1'b0, 3'd6, 3'd3, 1'b0, 8'h00, 16'h6666, 0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_tag = 3'd7; req_set = 3'd3; req_offset = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0; c = 0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            seen = mem_req_valid;
        end
        n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rf_fill_req got=%b exp=1", seen); end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rf_req_ready got=%b exp=1", req_ready); end
        n_tests++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rf_mem_valid got=%b exp=0", mem_req_valid); end
        n_tests++; if ({hit_cnt, miss_cnt} !== 32'd0) begin n_fail++; $display("FAIL rf_counters got=%h exp=0", {hit_cnt, miss_cnt}); end
        mem_resp_valid = 1'b1; mem_resp_block = 16'hDEAD;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid || mem_req_valid || !req_ready) stray = 1'b1;
            @(negedge clk);
        end
        n_tests++; if (stray !== 1'b0) begin n_fail++; $display("FAIL rf_stale_ignored got=%b exp=0", stray); end
        issue(1'b0, 3'd6, 3'd3, 1'b0, 8'h00, 16'h0F0F, 0);
        n_tests++; if ({got_hit, got_rdata} !== {1'b0, 8'h0F}) begin n_fail++; $display("FAIL rf_tag6_miss got=%b/%h exp=0/0f", got_hit, got_rdata); end
        n_tests++; if ({hit_cnt, miss_cnt} !== {16'd0, 16'd1}) begin n_fail++; $display("FAIL rf_cnts got=%0d/%0d exp=0/1", hit_cnt, miss_cnt); end
    endtask

    initial begin
        timeouts = 0;
        test_reset();
        test_cold_miss();
        test_write_hit();
        test_dirty_evict();
        test_clean_evict();
        test_backpressure();
        test_reset_in_fill();
        n_tests++; if (timeouts !== 0) begin n_fail++; $display("FAIL resp_timeouts got=%0d exp=0", timeouts); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
